// File: rtl/ks_data_path_p.sv
// K&S datapath: PC, IR/decoder, register file, 8-op ALU, flag register, RAM address mux.
// Optional branch-and-link / return support is enabled by defining KS_LINK_EN.
package k_and_s_pkg;
   typedef enum logic [3:0] {
      I_NOP, I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR,
      I_BRANCH, I_BZERO, I_BNEG, I_BOV, I_BNOV, I_BNNEG, I_BNZERO, I_HALT
   } decoded_instruction_type;
endpackage

module ks_data_path_p
   import k_and_s_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 5,
   parameter int NREGS  = 4
) (
   input  logic                    clk,
   input  logic                    rst,
`ifdef KS_LINK_EN
   input  logic                    link,
   input  logic                    ret,
`endif
   input  logic                    branch,
   input  logic                    pc_enable,
   input  logic                    ir_enable,
   input  logic                    addr_sel,
   input  logic                    c_sel,
   input  logic [2:0]              operation,
   input  logic                    write_reg_enable,
   input  logic                    flags_reg_enable,
   output decoded_instruction_type decoded_instruction,
   output logic                    zero_op,
   output logic                    neg_op,
   output logic                    unsigned_overflow,
   output logic                    signed_overflow,
   output logic [ADDR_W-1:0]       ram_addr,
   output logic [DATA_W-1:0]       data_out,
   input  logic [DATA_W-1:0]       data_in
);
   localparam int RW = $clog2(NREGS);

   logic [ADDR_W-1:0] pc_q, pc_d, mem_addr;
   logic [DATA_W-1:0] ir_q, ir_d;
   logic [DATA_W-1:0] regs_q [NREGS];
   logic [DATA_W-1:0] regs_d [NREGS];
   logic              zero_q, zero_d, neg_q, neg_d, uovf_q, uovf_d, sovf_q, sovf_d;
   logic [RW-1:0]     a_addr, b_addr, c_addr;
   logic [DATA_W-1:0] bus_a, bus_b, bus_c, alu_res;
   logic [DATA_W:0]   sum;
   logic              alu_c, alu_v;
   logic [7:0]        opcode;
   logic              ir_bits_unused;
`ifdef KS_LINK_EN
   logic [ADDR_W-1:0] link_q, link_d;
`endif

   always_comb begin
      decoded_instruction = I_NOP;
      a_addr              = '0;
      b_addr              = '0;
      c_addr              = '0;
      mem_addr            = '0;
      opcode              = ir_q[DATA_W-1 -: 8];
      ir_bits_unused      = ^ir_q;
      case (opcode)
         8'h81: begin decoded_instruction = I_LOAD;  c_addr = ir_q[ADDR_W +: RW]; mem_addr = ir_q[ADDR_W-1:0]; end
         8'h82: begin decoded_instruction = I_STORE; a_addr = ir_q[ADDR_W +: RW]; mem_addr = ir_q[ADDR_W-1:0]; end
         8'h91: begin
            decoded_instruction = I_MOVE;
            c_addr = ir_q[RW +: RW];
            a_addr = ir_q[0 +: RW];
            b_addr = ir_q[0 +: RW];
         end
         8'hA1, 8'hA2, 8'hA3, 8'hA4: begin
            case (opcode[2:0])
               3'd1:    decoded_instruction = I_ADD;
               3'd2:    decoded_instruction = I_SUB;
               3'd3:    decoded_instruction = I_AND;
               default: decoded_instruction = I_OR;
            endcase
            a_addr = ir_q[0 +: RW];
            b_addr = ir_q[RW +: RW];
            c_addr = ir_q[2*RW +: RW];
         end
         8'h01: begin decoded_instruction = I_BRANCH; mem_addr = ir_q[ADDR_W-1:0]; end
         8'h02: begin decoded_instruction = I_BZERO;  mem_addr = ir_q[ADDR_W-1:0]; end
         8'h03: begin decoded_instruction = I_BNEG;   mem_addr = ir_q[ADDR_W-1:0]; end
         8'h05: begin decoded_instruction = I_BOV;    mem_addr = ir_q[ADDR_W-1:0]; end
         8'h06: begin decoded_instruction = I_BNOV;   mem_addr = ir_q[ADDR_W-1:0]; end
         8'h0A: begin decoded_instruction = I_BNNEG;  mem_addr = ir_q[ADDR_W-1:0]; end
         8'h0B: begin decoded_instruction = I_BNZERO; mem_addr = ir_q[ADDR_W-1:0]; end
         8'hFF: decoded_instruction = I_HALT;
         default: ;
      endcase
   end

   always_comb begin
      bus_a   = regs_q[a_addr];
      bus_b   = regs_q[b_addr];
      sum     = '0;
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (operation)
         3'b000: alu_res = bus_a | bus_b;
         3'b001: begin
            sum     = {1'b0, bus_a} + {1'b0, bus_b};
            alu_res = sum[DATA_W-1:0];
            alu_c   = sum[DATA_W];
            // carry into the MSB recovered from the MSB sum bit and its operands
            alu_v   = (sum[DATA_W-1] ^ bus_a[DATA_W-1] ^ bus_b[DATA_W-1]) ^ sum[DATA_W];
         end
         3'b010: begin
            sum     = {1'b0, bus_a} + {1'b0, ~bus_b} + (DATA_W+1)'(1);
            alu_res = sum[DATA_W-1:0];
            alu_c   = sum[DATA_W];
            alu_v   = (sum[DATA_W-1] ^ bus_a[DATA_W-1] ^ ~bus_b[DATA_W-1]) ^ sum[DATA_W];
         end
         3'b011: alu_res = bus_a & bus_b;
         3'b100: alu_res = bus_a ^ bus_b;
         3'b101: begin
            alu_res = {bus_a[DATA_W-2:0], 1'b0};
            alu_c   = bus_a[DATA_W-1];
            alu_v   = bus_a[DATA_W-1] ^ bus_a[DATA_W-2];
         end
         3'b110: begin
            alu_res = {1'b0, bus_a[DATA_W-1:1]};
            alu_c   = bus_a[0];
         end
         default: alu_res = bus_a;
      endcase
   end

   always_comb begin
      bus_c    = c_sel ? alu_res : data_in;
      ram_addr = addr_sel ? mem_addr : pc_q;
      data_out = bus_a;
      pc_d     = pc_q;
`ifdef KS_LINK_EN
      link_d   = link_q;
      if (pc_enable) begin
         if (ret) begin
            pc_d = link_q;
         end else if (branch) begin
            pc_d = mem_addr;
            if (link) link_d = pc_q + ADDR_W'(1);
         end else begin
            pc_d = pc_q + ADDR_W'(1);
         end
      end
`else
      if (pc_enable) pc_d = branch ? mem_addr : pc_q + ADDR_W'(1);
`endif
      ir_d = ir_enable ? data_in : ir_q;
      regs_d = regs_q;
      if (write_reg_enable) regs_d[c_addr] = bus_c;
      zero_d = zero_q;
      neg_d  = neg_q;
      uovf_d = uovf_q;
      sovf_d = sovf_q;
      if (flags_reg_enable) begin
         zero_d = (alu_res == '0);
         neg_d  = alu_res[DATA_W-1];
         uovf_d = alu_c;
         sovf_d = alu_v;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q   <= '0;
         ir_q   <= '0;
         regs_q <= '{default: '0};
         zero_q <= 1'b0;
         neg_q  <= 1'b0;
         uovf_q <= 1'b0;
         sovf_q <= 1'b0;
`ifdef KS_LINK_EN
         link_q <= '0;
`endif
      end else begin
         pc_q   <= pc_d;
         ir_q   <= ir_d;
         regs_q <= regs_d;
         zero_q <= zero_d;
         neg_q  <= neg_d;
         uovf_q <= uovf_d;
         sovf_q <= sovf_d;
`ifdef KS_LINK_EN
         link_q <= link_d;
`endif
      end
   end

   assign zero_op           = zero_q;
   assign neg_op            = neg_q;
   assign unsigned_overflow = uovf_q;
   assign signed_overflow   = sovf_q;

endmodule

// File: tb/tb_ks_data_path_p.sv
// Directed bench for ks_data_path_p: a behavioural model checked every cycle plus hand-computed literals.
module tb_ks_data_path_p;
   import k_and_s_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        branch, pc_enable, ir_enable, addr_sel, c_sel;
   logic [2:0]  operation;
   logic        write_reg_enable, flags_reg_enable;
   logic [15:0] data_in;
   decoded_instruction_type decoded_instruction;
   logic        zero_op, neg_op, unsigned_overflow, signed_overflow;
   logic [4:0]  ram_addr;
   logic [15:0] data_out;
`ifdef KS_LINK_EN
   logic        link, ret;
`endif

   int checks = 0;
   int errors = 0;
   logic check_en = 1'b0;

   always #5 clk = ~clk;

   ks_data_path_p #(.DATA_W(16), .ADDR_W(5), .NREGS(4)) dut (
      .clk(clk), .rst(rst),
`ifdef KS_LINK_EN
      .link(link), .ret(ret),
`endif
      .branch(branch), .pc_enable(pc_enable), .ir_enable(ir_enable), .addr_sel(addr_sel),
      .c_sel(c_sel), .operation(operation), .write_reg_enable(write_reg_enable),
      .flags_reg_enable(flags_reg_enable), .decoded_instruction(decoded_instruction),
      .zero_op(zero_op), .neg_op(neg_op), .unsigned_overflow(unsigned_overflow),
      .signed_overflow(signed_overflow), .ram_addr(ram_addr), .data_out(data_out),
      .data_in(data_in)
   );

   // ---------------- behavioural model ----------------
   typedef struct packed {
      decoded_instruction_type t;
      logic [1:0] a, b, c;
      logic [4:0] ma;
   } dec_t;

   logic [15:0] m_regs [4];
   logic [4:0]  m_pc, m_link;
   logic [15:0] m_ir;
   logic        m_z, m_n, m_u, m_s;

   function automatic dec_t m_decode(input logic [15:0] ir);
      dec_t d;
      d.t = I_NOP; d.a = 2'd0; d.b = 2'd0; d.c = 2'd0; d.ma = 5'd0;
      case (ir[15:8])
         8'h81: begin d.t = I_LOAD;  d.c = ir[6:5]; d.ma = ir[4:0]; end
         8'h82: begin d.t = I_STORE; d.a = ir[6:5]; d.ma = ir[4:0]; end
         8'h91: begin d.t = I_MOVE;  d.c = ir[3:2]; d.a = ir[1:0]; d.b = ir[1:0]; end
         8'hA1: begin d.t = I_ADD; d.a = ir[1:0]; d.b = ir[3:2]; d.c = ir[5:4]; end
         8'hA2: begin d.t = I_SUB; d.a = ir[1:0]; d.b = ir[3:2]; d.c = ir[5:4]; end
         8'hA3: begin d.t = I_AND; d.a = ir[1:0]; d.b = ir[3:2]; d.c = ir[5:4]; end
         8'hA4: begin d.t = I_OR;  d.a = ir[1:0]; d.b = ir[3:2]; d.c = ir[5:4]; end
         8'h01: begin d.t = I_BRANCH; d.ma = ir[4:0]; end
         8'h02: begin d.t = I_BZERO;  d.ma = ir[4:0]; end
         8'h03: begin d.t = I_BNEG;   d.ma = ir[4:0]; end
         8'h05: begin d.t = I_BOV;    d.ma = ir[4:0]; end
         8'h06: begin d.t = I_BNOV;   d.ma = ir[4:0]; end
         8'h0A: begin d.t = I_BNNEG;  d.ma = ir[4:0]; end
         8'h0B: begin d.t = I_BNZERO; d.ma = ir[4:0]; end
         8'hFF: d.t = I_HALT;
         default: ;
      endcase
      return d;
   endfunction

   // returns {result, unsigned overflow, signed overflow}
   function automatic logic [17:0] m_alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
      logic [16:0] w;
      logic [15:0] r;
      logic u, s;
      u = 1'b0; s = 1'b0;
      case (op)
         3'd0: r = a | b;
         3'd1: begin w = {1'b0, a} + {1'b0, b}; r = w[15:0]; u = w[16];
                     s = (a[15] == b[15]) && (r[15] != a[15]); end
         3'd2: begin r = a - b; u = (a >= b); s = (a[15] != b[15]) && (r[15] != a[15]); end
         3'd3: r = a & b;
         3'd4: r = a ^ b;
         3'd5: begin r = a << 1; u = a[15]; s = a[15] ^ a[14]; end
         3'd6: begin r = a >> 1; u = a[0]; end
         default: r = a;
      endcase
      return {r, u, s};
   endfunction

   dec_t        md;
   logic [17:0] mr;
   logic [4:0]  npc;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) m_regs[i] = '0;
         m_pc = '0; m_ir = '0; m_link = '0;
         m_z = 0; m_n = 0; m_u = 0; m_s = 0;
      end else begin
         md  = m_decode(m_ir);
         mr  = m_alu(operation, m_regs[md.a], m_regs[md.b]);
         npc = m_pc;
         if (pc_enable) begin
`ifdef KS_LINK_EN
            if (ret) npc = m_link;
            else if (branch) begin
               npc = md.ma;
               if (link) m_link = m_pc + 5'd1;
            end else npc = m_pc + 5'd1;
`else
            npc = branch ? md.ma : m_pc + 5'd1;
`endif
         end
         if (write_reg_enable) m_regs[md.c] = c_sel ? mr[17:2] : data_in;
         if (flags_reg_enable) begin
            m_z = (mr[17:2] == 16'h0000);
            m_n = mr[17];
            m_u = mr[1];
            m_s = mr[0];
         end
         if (ir_enable) m_ir = data_in;
         m_pc = npc;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   dec_t cd;
   always @(posedge clk) begin
      #1;
      if (check_en && !rst) begin
         cd = m_decode(m_ir);
         chk("cmp_decoded", 32'(decoded_instruction), 32'(cd.t));
         chk("cmp_ram_addr", 32'(ram_addr), 32'(addr_sel ? cd.ma : m_pc));
         chk("cmp_data_out", 32'(data_out), 32'(m_regs[cd.a]));
         chk("cmp_flags", 32'({zero_op, neg_op, unsigned_overflow, signed_overflow}),
             32'({m_z, m_n, m_u, m_s}));
      end
   end

   // ---------------- stimulus ----------------
   task automatic nxt();
      @(negedge clk);
      branch = 0; pc_enable = 0; ir_enable = 0; addr_sel = 0; c_sel = 0;
      operation = 3'd0; write_reg_enable = 0; flags_reg_enable = 0; data_in = '0;
`ifdef KS_LINK_EN
      link = 0; ret = 0;
`endif
   endtask

   task automatic write_reg(input logic [1:0] k, input logic [15:0] val);
      nxt(); ir_enable = 1; data_in = {8'h81, 1'b0, k, 5'b0};
      nxt(); write_reg_enable = 1; data_in = val;
   endtask

   task automatic read_reg(input logic [1:0] k, input logic [15:0] exp, input string name);
      nxt(); ir_enable = 1; data_in = {8'h82, 1'b0, k, 5'b0};
      nxt(); #1 chk(name, 32'(data_out), 32'(exp));
   endtask

   task automatic alu_op(input logic [15:0] instr, input logic [2:0] op);
      nxt(); ir_enable = 1; data_in = instr;
      nxt(); operation = op; c_sel = 1; write_reg_enable = 1; flags_reg_enable = 1;
   endtask

   task automatic chk_flags(input string name, input logic [3:0] exp_zncs);
      nxt(); #1 chk(name, 32'({zero_op, neg_op, unsigned_overflow, signed_overflow}), 32'(exp_zncs));
   endtask

   initial begin
      rst = 0;
      branch = 0; pc_enable = 0; ir_enable = 0; addr_sel = 0; c_sel = 0;
      operation = 3'd0; write_reg_enable = 0; flags_reg_enable = 0; data_in = '0;
`ifdef KS_LINK_EN
      link = 0; ret = 0;
`endif
      #2 rst = 1;
      nxt(); nxt();
      rst = 0;
      check_en = 1;
      #1;
      chk("init_ram_addr", 32'(ram_addr), 32'd0);
      chk("init_decoded", 32'(decoded_instruction), 32'(I_NOP));
      chk("init_flags", 32'({zero_op, neg_op, unsigned_overflow, signed_overflow}), 32'd0);

      // ADD overflow into the sign bit
      write_reg(2'd0, 16'h7FFF);
      write_reg(2'd1, 16'h0001);
      alu_op(16'hA124, 3'b001);
      chk_flags("add_flags", 4'b0101);
      read_reg(2'd2, 16'h8000, "add_r2");

      // SUB equal operands: zero with no borrow
      write_reg(2'd0, 16'h0005);
      write_reg(2'd1, 16'h0005);
      alu_op(16'hA224, 3'b010);
      chk_flags("sub_flags", 4'b1010);
      read_reg(2'd2, 16'h0000, "sub_r2");

      // SHL with both overflow flags
      write_reg(2'd0, 16'h8001);
      alu_op(16'hA124, 3'b101);
      chk_flags("shl_flags", 4'b0011);
      read_reg(2'd2, 16'h0002, "shl_r2");

      // every ALU op on one operand pair
      write_reg(2'd0, 16'hA5F0);
      write_reg(2'd1, 16'h0FF3);
      for (int op = 0; op < 8; op++) begin
         alu_op(16'hA124, 3'(op));
         if (op == 4) read_reg(2'd2, 16'hAA03, "xor_r2");
         if (op == 6) read_reg(2'd2, 16'h52F8, "shr_r2");
      end

      // LOAD into R3, then same-register read/write in one cycle
      nxt(); ir_enable = 1; data_in = 16'h8163;
      nxt(); #1 chk("load_decode", 32'(decoded_instruction), 32'(I_LOAD));
      write_reg_enable = 1; data_in = 16'hBEEF;
      read_reg(2'd3, 16'hBEEF, "load_r3");
      nxt(); ir_enable = 1; data_in = 16'hA137;
      nxt(); operation = 3'b001; c_sel = 1; write_reg_enable = 1; flags_reg_enable = 1;
      #1 chk("same_reg_old", 32'(data_out), 32'hBEEF);
      nxt(); #1 chk("same_reg_new", 32'(data_out), 32'hCEE2);

      // PC increment to the top and wrap, then branch
      for (int i = 0; i < 31; i++) begin nxt(); pc_enable = 1; end
      nxt(); #1 chk("pc_top", 32'(ram_addr), 32'd31);
      pc_enable = 1;
      nxt(); #1 chk("pc_wrap", 32'(ram_addr), 32'd0);
      ir_enable = 1; data_in = 16'h0113;
      nxt(); #1 chk("branch_decode", 32'(decoded_instruction), 32'(I_BRANCH));
      pc_enable = 1; branch = 1;
      nxt(); addr_sel = 1; #1 chk("branch_mem_addr", 32'(ram_addr), 32'h13);
      addr_sel = 0; #1 chk("branch_pc", 32'(ram_addr), 32'h13);

      // asynchronous reset in the middle of a cycle
      write_reg(2'd1, 16'h1234);
      nxt(); ir_enable = 1; data_in = 16'h0107;
      nxt(); pc_enable = 1; branch = 1;
      nxt(); #1 chk("pc_before_rst", 32'(ram_addr), 32'd7);
      #2 rst = 1;
      #1;
      chk("rst_pc", 32'(ram_addr), 32'd0);
      chk("rst_decoded", 32'(decoded_instruction), 32'(I_NOP));
      chk("rst_flags", 32'({zero_op, neg_op, unsigned_overflow, signed_overflow}), 32'd0);
      chk("rst_bus_a", 32'(data_out), 32'd0);
      nxt(); nxt();
      rst = 0;
      for (int k = 0; k < 4; k++) read_reg(2'(k), 16'h0000, "rst_reg");

`ifdef KS_LINK_EN
      for (int i = 0; i < 4; i++) begin nxt(); pc_enable = 1; end
      nxt(); ir_enable = 1; data_in = 16'h0110;
      nxt(); pc_enable = 1; branch = 1; link = 1;
      nxt(); #1 chk("bl_pc", 32'(ram_addr), 32'h10);
      pc_enable = 1; ret = 1;
      nxt(); #1 chk("ret_pc", 32'(ram_addr), 32'd5);
      pc_enable = 1; branch = 1;
      nxt(); #1 chk("b_pc", 32'(ram_addr), 32'h10);
      pc_enable = 1; ret = 1; branch = 1;
      nxt(); #1 chk("ret_prio_pc", 32'(ram_addr), 32'd5);
`endif

      nxt(); nxt();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
